// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  // Register address bus width.
  localparam int unsigned REG_ADDR_BUS = 5;

  // Operand source selects for the ID-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EX      = 2'd1,
    FWD_MEM     = 2'd2,
    FWD_WB      = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode <-> hazard scoreboard bus: read/write requests in, stall and selects out.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_BUS
);

  logic                  id_valid;
  logic                  id_read_en_1;
  logic [REG_ADDR_W-1:0] id_read_addr_1;
  logic                  id_read_en_2;
  logic [REG_ADDR_W-1:0] id_read_addr_2;
  logic                  id_write_en;
  logic [REG_ADDR_W-1:0] id_write_addr;
  logic                  id_is_load;
  logic                  flush;
  logic                  stall_req;
  logic [1:0]            fwd_sel_1;
  logic [1:0]            fwd_sel_2;

  // Decode side.
  modport master (
    output id_valid, id_read_en_1, id_read_addr_1, id_read_en_2, id_read_addr_2,
           id_write_en, id_write_addr, id_is_load, flush,
    input  stall_req, fwd_sel_1, fwd_sel_2
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_read_en_1, id_read_addr_1, id_read_en_2, id_read_addr_2,
           id_write_en, id_write_addr, id_is_load, flush,
    output stall_req, fwd_sel_1, fwd_sel_2
  );

endinterface

// File: rtl/hazard_scoreboard_port_check.sv
// Per-read-port hazard check: youngest-first slot match, forwarding select
// and load-use detection.
module hazard_port_check
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_BUS,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                  id_valid,
  input  logic                  rd_en,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_addr,
  input  logic                  ex_is_load,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  output logic [1:0]            fwd_sel,
  output logic                  load_use
);

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  // Priority match EX > MEM > WB; a load still in EX cannot forward yet.
  always_comb begin
    fwd_sel  = FWD_REGFILE;
    load_use = 1'b0;
    if (id_valid && rd_en && (rd_addr != ZERO_ADDR)) begin
      if (ex_valid && (ex_addr == rd_addr)) begin
        if (ex_is_load) load_use = 1'b1;
        else            fwd_sel  = FWD_EX;
      end else if (mem_valid && (mem_addr == rd_addr)) begin
        fwd_sel = FWD_MEM;
      end else if (wb_valid && (wb_addr == rd_addr)) begin
        fwd_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks destinations of the EX/MEM/WB
// instructions and drives stall and operand forwarding selects.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_BUS,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic              clk,
  input  logic              rst,
  hazard_scoreboard_if.slave bus
);

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  // The load flag only matters while the load is in EX; once in MEM/WB its
  // result is forwardable, so only the EX slot keeps it.
  logic                  ex_valid, mem_valid, wb_valid;
  logic [REG_ADDR_W-1:0] ex_addr, mem_addr, wb_addr;
  logic                  ex_is_load;

  logic                  load_use_1, load_use_2;
  logic                  issue;
  logic                  new_valid;

  hazard_port_check #(
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_port_1 (
    .id_valid   (bus.id_valid),
    .rd_en      (bus.id_read_en_1),
    .rd_addr    (bus.id_read_addr_1),
    .ex_valid   (ex_valid),
    .ex_addr    (ex_addr),
    .ex_is_load (ex_is_load),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .fwd_sel    (bus.fwd_sel_1),
    .load_use   (load_use_1)
  );

  hazard_port_check #(
    .REG_ADDR_W (REG_ADDR_W),
    .ZERO_REG   (ZERO_REG)
  ) u_port_2 (
    .id_valid   (bus.id_valid),
    .rd_en      (bus.id_read_en_2),
    .rd_addr    (bus.id_read_addr_2),
    .ex_valid   (ex_valid),
    .ex_addr    (ex_addr),
    .ex_is_load (ex_is_load),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .fwd_sel    (bus.fwd_sel_2),
    .load_use   (load_use_2)
  );

  // Stall on any load-use hazard unless flushing; only issued writers enter EX.
  always_comb begin
    bus.stall_req = (load_use_1 | load_use_2) & ~bus.flush;
    issue         = bus.id_valid & ~bus.stall_req & ~bus.flush;
    new_valid     = issue & bus.id_write_en & (bus.id_write_addr != ZERO_ADDR);
  end

  // Slot pipeline advance; EX takes a bubble on stall/flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_addr    <= '0;
      ex_is_load <= 1'b0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
    end else begin
      wb_valid   <= mem_valid;
      wb_addr    <= mem_addr;
      mem_valid  <= ex_valid;
      mem_addr   <= ex_addr;
      ex_valid   <= new_valid;
      ex_addr    <= bus.id_write_addr;
      ex_is_load <= bus.id_is_load;
    end
  end

endmodule
